// File: rtl/sm_result_display_if.sv
// Result handshake between the adder stage and the display sequencer.
//   res_in    : sign-magnitude result {sign, overflow, magnitude[3:0]}
//   res_valid : res_in holds a result to be displayed
//   res_ready : the display can accept a result this cycle
// master = producer (adder stage), slave = consumer (display).
interface sm_result_display_if;
  logic [5:0] res_in;
  logic       res_valid;
  logic       res_ready;

  modport master (output res_in, output res_valid, input res_ready);
  modport slave  (input res_in, input res_valid, output res_ready);
endinterface

// File: rtl/sm_result_display.sv
// Time-multiplexed single-digit display of a sign-magnitude result.
// Shows one frame of slots, each held HOLD_CYCLES clocks:
//   SIGN ('-' or blank), TENS ('1' or blank), ONES (digit), GAP (blank, dp=1).
// The frame repeats until a new result is accepted (in IDLE or GAP).
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : result handshake (slave side)
//   seg  : registered segment drive, bit6..0 = g,f,e,d,c,b,a
//   dp   : registered decimal point, high only in GAP (end-of-frame marker)
//   busy : registered, high whenever not IDLE
module sm_result_display #(
  parameter int unsigned HOLD_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  sm_result_display_if.slave   bus,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic                 busy
);

  localparam logic [15:0] LAST = 16'(HOLD_CYCLES - 1);

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b0000110;
  localparam logic [6:0] SEG_E     = 7'b1111001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN,
    S_TENS,
    S_ONES,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  val_q, val_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        busy_q, busy_d;

  logic        ready;
  logic        xfer;
  logic        slot_end;
  logic [3:0]  mag;
  logic        tens;
  logic [3:0]  ones;

  function automatic logic [6:0] digit7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign ready         = (state_q == S_IDLE) || (state_q == S_GAP);
  assign bus.res_ready = ready;
  assign xfer          = bus.res_valid && ready;
  assign slot_end      = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;

    case (state_q)
      S_IDLE: ;
      S_SIGN: begin
        if (slot_end) begin
          state_d = S_TENS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_TENS: begin
        if (slot_end) begin
          state_d = S_ONES;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ONES: begin
        if (slot_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (slot_end) begin
          state_d = S_SIGN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A transfer (IDLE or GAP only) overrides the slot sequencing above.
    if (xfer) begin
      state_d = S_SIGN;
      cnt_d   = '0;
      val_d   = bus.res_in;
    end
  end

  // Outputs are decoded from the next state/value so they are registered;
  // they only differ from the current outputs on an edge that changes state.
  assign mag  = val_d[3:0];
  assign tens = (mag >= 4'd10);
  assign ones = tens ? (mag - 4'd10) : mag;

  always_comb begin
    seg_d  = SEG_BLANK;
    dp_d   = (state_d == S_GAP);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_SIGN: seg_d = (val_d[5] && (mag != 4'd0)) ? SEG_MINUS : SEG_BLANK;
      S_TENS: seg_d = val_d[4] ? SEG_E : (tens ? SEG_ONE : SEG_BLANK);
      S_ONES: seg_d = val_d[4] ? SEG_E : digit7(ones);
      default: seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      busy_q  <= busy_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = busy_q;

endmodule
